apb_frame_splitter: RTL and testbench
=====================================

Name: apb_frame_splitter

Overview:
- Parametrised successor to the decoder-to-APB data stage.
- Accepts one decoded RAH packet at a time over a valid/ready handshake.
- Write packets are serialised into WRITE_DATA_WIDTH beats toward the APB master, with a one-hot slave select.
- Config packets are forwarded as a single config transfer.
- Adds backpressure, configurable beat counts, slave-id range checking and last-beat marking.

Parameters:
RAH_PACKET_WIDTH, 48, decoded packet width; must be an integer multiple of WRITE_DATA_WIDTH
WRITE_DATA_WIDTH, 16, width of one write beat
CONFIG_DATA_WIDTH, 40, config payload width; must be <= RAH_PACKET_WIDTH
LENGTH_WIDTH, 8, width of length and address fields
SLV_ID_WIDTH, 7, width of incoming slave id
NUM_SLAVES, 4, number of APB slaves; width of one-hot selects
FIRST_BEATS, 2, beats in a first_frame packet; 1..NUM_BEATS
WRITE_ADDR, 8'hB3, constant write address driven with each beat
CONFIG_ADDR, 8'hB3, constant config address
(derived) NUM_BEATS = RAH_PACKET_WIDTH/WRITE_DATA_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  packet present
in_ready  out  1  block can accept a packet
slv_id  in  SLV_ID_WIDTH  target slave index
length  in  LENGTH_WIDTH  packet length field, passed through
wr_data  in  RAH_PACKET_WIDTH  packet payload
cfg_sel  in  1  1 = config packet, 0 = write packet
first_frame  in  1  first frame of a transfer (short packet)
wr_valid  out  1  write beat valid
wr_ready  in  1  APB master accepts beat
write_data  out  WRITE_DATA_WIDTH  beat payload
write_sel  out  NUM_SLAVES  one-hot slave select
write_addr  out  LENGTH_WIDTH  WRITE_ADDR while wr_valid, else 0
write_len  out  LENGTH_WIDTH  latched length
data_hold_flag  out  1  beat 0 of a continuation packet
last_beat  out  1  final beat of the packet
cfg_valid  out  1  config transfer valid
cfg_ready  in  1  config consumer accepts
config_sel  out  NUM_SLAVES  one-hot config target
config_addr  out  LENGTH_WIDTH  CONFIG_ADDR while cfg_valid, else 0
config_data  out  CONFIG_DATA_WIDTH  wr_data[CONFIG_DATA_WIDTH-1:0]
err_slv_id  out  1  one-cycle pulse on an out-of-range slave id

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0, including in_ready, wr_valid, cfg_valid and err_slv_id; beat counter 0. Reset overrides any in-flight burst or config; partial bursts are discarded.
- in_ready = 1 iff state==IDLE and rst_n==1.
- FSM states: IDLE, WRITE, CONFIG.
- IDLE, on in_valid && in_ready: latch slv_id, length, wr_data, first_frame.
  - slv_id >= NUM_SLAVES: stay in IDLE, err_slv_id=1 on the next cycle only, packet dropped.
  - Else cfg_sel=1: go to CONFIG.
  - Else: go to WRITE with N = first_frame ? FIRST_BEATS : NUM_BEATS and beat k=0.
- Latency: packet accepted at edge T -> wr_valid or cfg_valid high from cycle T+1.
- WRITE:
  - wr_valid=1.
  - write_data = latched_data[(N-1-k)*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH]: the most significant beat goes first. A first frame uses only the low FIRST_BEATS*WRITE_DATA_WIDTH bits.
  - write_sel = 1<<slv_id.
  - data_hold_flag = !first_frame && k==0.
  - last_beat = (k==N-1).
  - Outputs hold stable while wr_ready=0.
  - On wr_ready: if k==N-1, go to IDLE (all write outputs 0 next cycle); else k<=k+1.
- CONFIG:
  - cfg_valid=1, config_sel = 1<<slv_id, config_data and config_addr stable.
  - On cfg_ready: go to IDLE.
- No packet is accepted in the cycle that completes the previous one. Minimum packet-to-packet gap is one IDLE cycle.
- in_valid while not in IDLE is ignored. The upstream holds the packet until in_ready.
- Write and config outputs are never valid simultaneously.

Test Plan:
- Write, non-first, slv_id=1, wr_data=48'hAAAA_BBBB_CCCC, wr_ready=1 -> beats AAAA/BBBB/CCCC on 3 consecutive cycles starting T+1. write_sel=4'b0010, data_hold_flag=1,0,0, last_beat=0,0,1, write_addr=8'hB3. in_ready returns one cycle after the last beat.
- Write, first_frame=1, slv_id=0, same data -> two beats BBBB, CCCC; data_hold_flag=0; last_beat on CCCC; write_sel=4'b0001.
- Backpressure: non-first packet, wr_ready=0 for 3 cycles during beat 1 -> write_data=BBBB held stable, wr_valid=1, no beat skipped; sequence completes AAAA, BBBB, CCCC; in_ready=0 throughout.
- Config: cfg_sel=1, slv_id=3, wr_data=48'h12_3456_789A_BC -> cfg_valid from T+1, config_data=40'h3456_789A_BC, config_sel=4'b1000, config_addr=8'hB3. cfg_ready held low 2 cycles, then high -> back to IDLE; wr_valid stays 0.
- Bad id: slv_id=5 with NUM_SLAVES=4 -> err_slv_id high exactly one cycle; no wr_valid or cfg_valid; next valid packet is accepted normally.
- Reset mid-burst: rst_n=0 during beat 1 -> next cycle all outputs 0, state IDLE. After release, in_ready=1 and a new packet starts at beat 0.

Source files
------------

// File: rtl/apb_frame_splitter.sv
// Splits decoded RAH packets into MSB-first APB write beats or a single config transfer.
// One packet in flight at a time. Out-of-range slave ids are dropped with a one-cycle error pulse.
module apb_frame_splitter #(
    parameter int RAH_PACKET_WIDTH  = 48,
    parameter int WRITE_DATA_WIDTH  = 16,
    parameter int CONFIG_DATA_WIDTH = 40,
    parameter int LENGTH_WIDTH      = 8,
    parameter int SLV_ID_WIDTH      = 7,
    parameter int NUM_SLAVES        = 4,
    parameter int FIRST_BEATS       = 2,
    parameter logic [LENGTH_WIDTH-1:0] WRITE_ADDR  = 8'hB3,
    parameter logic [LENGTH_WIDTH-1:0] CONFIG_ADDR = 8'hB3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLV_ID_WIDTH-1:0]      slv_id,
    input  logic [LENGTH_WIDTH-1:0]      length,
    input  logic [RAH_PACKET_WIDTH-1:0]  wr_data,
    input  logic                         cfg_sel,
    input  logic                         first_frame,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [WRITE_DATA_WIDTH-1:0]  write_data,
    output logic [NUM_SLAVES-1:0]        write_sel,
    output logic [LENGTH_WIDTH-1:0]      write_addr,
    output logic [LENGTH_WIDTH-1:0]      write_len,
    output logic                         data_hold_flag,
    output logic                         last_beat,
    output logic                         cfg_valid,
    input  logic                         cfg_ready,
    output logic [NUM_SLAVES-1:0]        config_sel,
    output logic [LENGTH_WIDTH-1:0]      config_addr,
    output logic [CONFIG_DATA_WIDTH-1:0] config_data,
    output logic                         err_slv_id
);

    localparam int NUM_BEATS = RAH_PACKET_WIDTH / WRITE_DATA_WIDTH;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, CONFIG} state_t;

    state_t                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic                          err_q, err_d;
    logic [SLV_ID_WIDTH-1:0]       slv_q;
    logic [LENGTH_WIDTH-1:0]       len_q;
    logic [RAH_PACKET_WIDTH-1:0]   data_q;
    logic                          first_q;

    logic                          accept;
    logic                          bad_id;
    logic [BEAT_W-1:0]             last_idx;
    logic [BEAT_W-1:0]             beat_idx;
    logic [WRITE_DATA_WIDTH-1:0]   beats [NUM_BEATS];

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign bad_id   = 32'(slv_id) >= NUM_SLAVES;

    // A first frame only carries FIRST_BEATS beats, taken from the low end of the payload.
    assign last_idx = first_q ? BEAT_W'(FIRST_BEATS - 1) : BEAT_W'(NUM_BEATS - 1);
    assign beat_idx = last_idx - beat_q;

    always_comb begin
        for (int i = 0; i < NUM_BEATS; i++) begin
            beats[i] = data_q[i*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    beat_d = '0;
                    if (bad_id) begin
                        err_d = 1'b1;
                    end else if (cfg_sel) begin
                        state_d = CONFIG;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (beat_q == last_idx) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            CONFIG: begin
                if (cfg_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Packet fields need no reset: every output using them is gated by the state.
    always_ff @(posedge clk) begin
        if (accept) begin
            slv_q   <= slv_id;
            len_q   <= length;
            data_q  <= wr_data;
            first_q <= first_frame;
        end
    end

    assign wr_valid       = (state_q == WRITE);
    assign write_data     = wr_valid ? beats[beat_idx] : '0;
    assign write_sel      = wr_valid ? (NUM_SLAVES'(1) << slv_q) : '0;
    assign write_addr     = wr_valid ? WRITE_ADDR : '0;
    assign write_len      = wr_valid ? len_q : '0;
    assign data_hold_flag = wr_valid && !first_q && (beat_q == '0);
    assign last_beat      = wr_valid && (beat_q == last_idx);

    assign cfg_valid      = (state_q == CONFIG);
    assign config_sel     = cfg_valid ? (NUM_SLAVES'(1) << slv_q) : '0;
    assign config_addr    = cfg_valid ? CONFIG_ADDR : '0;
    assign config_data    = cfg_valid ? data_q[CONFIG_DATA_WIDTH-1:0] : '0;
    assign err_slv_id     = err_q;

endmodule

// File: tb/tb_apb_frame_splitter.sv
// Bench for apb_frame_splitter: directed scenarios plus randomized packets with random backpressure,
// checked against a transaction-level model (expected beat queue per packet).
module tb_apb_frame_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  slv_id;
    logic [7:0]  length;
    logic [47:0] wr_data;
    logic        cfg_sel;
    logic        first_frame;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] write_data;
    logic [3:0]  write_sel;
    logic [7:0]  write_addr;
    logic [7:0]  write_len;
    logic        data_hold_flag;
    logic        last_beat;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  config_sel;
    logic [7:0]  config_addr;
    logic [39:0] config_data;
    logic        err_slv_id;

    int n_checks = 0;
    int n_errors = 0;

    apb_frame_splitter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .slv_id(slv_id), .length(length), .wr_data(wr_data), .cfg_sel(cfg_sel),
        .first_frame(first_frame), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .write_data(write_data), .write_sel(write_sel), .write_addr(write_addr),
        .write_len(write_len), .data_hold_flag(data_hold_flag), .last_beat(last_beat),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .config_sel(config_sel),
        .config_addr(config_addr), .config_data(config_data), .err_slv_id(err_slv_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive harmless traffic on the input side while the block is busy.
    task automatic noise_inputs();
        in_valid    = ($urandom_range(0, 3) == 0);
        slv_id      = 7'($urandom_range(0, 6));
        cfg_sel     = 1'($urandom);
        first_frame = 1'($urandom);
        wr_data     = {16'($urandom), 32'($urandom)};
        length      = 8'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valids"}, {wr_valid, cfg_valid, err_slv_id}, 3'b000);
        chk({tag, "_wsel"}, {write_sel, write_addr, write_len, write_data}, 36'h0);
        chk({tag, "_flags"}, {data_hold_flag, last_beat}, 2'b00);
        chk({tag, "_cfg"}, {config_sel, config_addr, config_data}, 52'h0);
    endtask

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    task automatic send(input logic [6:0] id, input logic [7:0] len, input logic [47:0] data,
                        input logic cfg, input logic ff);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("send_in_ready", in_ready, 1'b1);
        slv_id = id; length = len; wr_data = data; cfg_sel = cfg; first_frame = ff;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // wmode: 0 random ready, 1 always ready, 2 stall three cycles on beat 1.
    task automatic run_write(input logic [6:0] id, input logic [7:0] len, input logic [47:0] data,
                             input logic ff, input int wmode);
        logic [15:0] q[$];
        int n = ff ? 2 : 3;
        int k = 0;
        int cyc = 0;
        int stalls = 0;
        for (int j = 0; j < n; j++) q.push_back(16'(data >> (16 * (n - 1 - j))));
        while (q.size() > 0 && cyc < 60) begin
            if (wmode == 1) wr_ready = 1'b1;
            else if (wmode == 2) begin
                wr_ready = !(k == 1 && stalls < 3);
                if (k == 1 && stalls < 3) stalls++;
            end else wr_ready = ($urandom_range(0, 2) != 0);
            noise_inputs();
            @(negedge clk);
            chk("wr_valid", {wr_valid, cfg_valid, in_ready}, 3'b100);
            chk("write_data", write_data, q[0]);
            chk("write_sel", write_sel, 4'b0001 << id);
            chk("write_addr", write_addr, 8'hB3);
            chk("write_len", write_len, len);
            chk("data_hold_flag", data_hold_flag, (!ff && k == 0));
            chk("last_beat", last_beat, (q.size() == 1));
            @(posedge clk); #1;
            if (wr_ready) begin
                void'(q.pop_front());
                k++;
            end
            cyc++;
        end
        if (q.size() > 0) chk("write_timeout", q.size(), 0);
        in_valid = 1'b0;
        wr_ready = 1'b0;
        @(negedge clk);
        chk("write_done_ready", in_ready, 1'b1);
        check_quiet("write_done");
        @(posedge clk); #1;
    endtask

    // cmode: 0 random ready, 1 ready held low two cycles then high.
    task automatic run_cfg(input logic [6:0] id, input logic [47:0] data, input int cmode);
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < 60) begin
            cfg_ready = (cmode == 1) ? (cyc >= 2) : ($urandom_range(0, 2) == 0);
            noise_inputs();
            @(negedge clk);
            chk("cfg_valid", {cfg_valid, wr_valid, in_ready}, 3'b100);
            chk("config_data", config_data, data[39:0]);
            chk("config_sel", config_sel, 4'b0001 << id);
            chk("config_addr", config_addr, 8'hB3);
            @(posedge clk); #1;
            if (cfg_ready) done = 1;
            cyc++;
        end
        if (!done) chk("cfg_timeout", 1'b0, 1'b1);
        in_valid  = 1'b0;
        cfg_ready = 1'b0;
        @(negedge clk);
        chk("cfg_done_ready", in_ready, 1'b1);
        check_quiet("cfg_done");
        @(posedge clk); #1;
    endtask

    task automatic run_packet(input logic [6:0] id, input logic [7:0] len, input logic [47:0] data,
                              input logic cfg, input logic ff, input int wmode, input int cmode);
        send(id, len, data, cfg, ff);
        if (id >= 4) begin
            @(negedge clk);
            chk("bad_id_err", {err_slv_id, wr_valid, cfg_valid, in_ready}, 4'b1001);
            @(posedge clk); #1;
            @(negedge clk);
            chk("bad_id_err_clear", {err_slv_id, wr_valid, cfg_valid}, 3'b000);
            @(posedge clk); #1;
        end else if (cfg) begin
            run_cfg(id, data, cmode);
        end else begin
            run_write(id, len, data, ff, wmode);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; slv_id = '0; length = '0; wr_data = '0;
        cfg_sel = 1'b0; first_frame = 1'b0; wr_ready = 1'b0; cfg_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1'b1);

        run_packet(7'd1, 8'h10, 48'hAAAA_BBBB_CCCC, 1'b0, 1'b0, 1, 0);
        run_packet(7'd0, 8'h20, 48'hAAAA_BBBB_CCCC, 1'b0, 1'b1, 1, 0);
        run_packet(7'd2, 8'h30, 48'hAAAA_BBBB_CCCC, 1'b0, 1'b0, 2, 0);
        run_packet(7'd3, 8'h40, 48'h12_3456_789A_BC, 1'b1, 1'b0, 0, 1);
        run_packet(7'd5, 8'h50, 48'h1111_2222_3333, 1'b0, 1'b0, 1, 0);
        run_packet(7'd1, 8'h60, 48'h4444_5555_6666, 1'b0, 1'b0, 1, 0);

        // Reset during beat 1 of a burst.
        send(7'd2, 8'h70, 48'hAAAA_BBBB_CCCC, 1'b0, 1'b0);
        wr_ready = 1'b1;
        @(negedge clk);
        chk("rst_burst_beat0", write_data, 16'hAAAA);
        @(posedge clk); #1;
        wr_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_burst_in_ready", in_ready, 1'b0);
        check_quiet("rst_burst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", in_ready, 1'b1);
        run_packet(7'd3, 8'h71, 48'hDEAD_BEEF_CAFE, 1'b0, 1'b0, 1, 0);

        for (int p = 0; p < 60; p++) begin
            logic [6:0]  id;
            logic [47:0] d;
            id = 7'($urandom_range(0, 6));
            d  = {16'($urandom), 32'($urandom)};
            run_packet(id, 8'($urandom), d, ($urandom_range(0, 2) == 0), 1'($urandom), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
